cfg_array_parser: RTL and testbench

CFG_ARRAY_PARSER -- requirements
Module: cfg_array_parser

---
 rtl/cfg_array_parser_pkg.sv | 53 +++++
 rtl/cfg_array_parser_len.sv | 27 ++
 rtl/cfg_array_parser.sv | 223 ++++++++++++++++++++++
 tb/tb_cfg_array_parser.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_array_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_array_parser_pkg
// Purpose  : Shared constants, state encoding and config record for the
//            capture configuration-array parser.
// Revision : 1.0
// ============================================================================
package cfg_array_parser_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [STATE_W-1:0] ST_MD1     = 4'd1;
    localparam logic [STATE_W-1:0] ST_ETH     = 4'd2;
    localparam logic [STATE_W-1:0] ST_ENC_MD0 = 4'd3;
    localparam logic [STATE_W-1:0] ST_ENC_MD1 = 4'd4;
    localparam logic [STATE_W-1:0] ST_PGM_CA  = 4'd5;
    localparam logic [STATE_W-1:0] ST_FSM_CA  = 4'd6;
    localparam logic [STATE_W-1:0] ST_SSM_CA  = 4'd7;
    localparam logic [STATE_W-1:0] ST_DISCARD = 4'd8;

    localparam logic [1:0] FLAG_HEAD = 2'b01;
    localparam logic [1:0] FLAG_MID  = 2'b11;
    localparam logic [1:0] FLAG_TAIL = 2'b10;

    localparam logic [15:0] ETHERTYPE = 16'hff01;
    localparam logic [3:0]  CFG_TYPE  = 4'h2;
    localparam logic [11:0] LEN_ADJ   = 12'd4;

    localparam logic [4:0] PGM_LINES = 5'd6;
    localparam logic [4:0] FSM_LINES = 5'd17;
    localparam logic [4:0] SSM_LINES = 5'd2;

    localparam int NUM_SLOTS = 8;
    localparam int RULE_W    = 104;

    typedef struct packed {
        logic [95:0]  pkt_len;
        logic [127:0] tb_size;
        logic [127:0] tb_rate;
        logic [831:0] rule;
        logic [831:0] mask;
        logic [15:0]  samp_freq;
        logic         test_stop;
        logic [19:0]  gcl_cycle;
    } cap_cfg_t;

    function automatic logic [11:0] len_sat(input logic [11:0] raw);
        return (raw < LEN_ADJ) ? 12'd0 : (raw - LEN_ADJ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_array_parser_len.sv
`default_nettype none
// ============================================================================
// Module   : cap_len_unpack
// Purpose  : Turns eight 16-bit length lanes into 12-bit lengths minus the
//            4-byte adjustment, clamped at zero.
// Revision : 1.0
// ============================================================================
module cap_len_unpack
    import cfg_array_parser_pkg::*;
(
    input  logic [127:0] i_lanes,
    output logic [95:0]  o_len
);

    logic [31:0] w_lane_hi;
    logic        w_unused_ok;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
        assign o_len[i*12 +: 12]   = len_sat(i_lanes[i*16 +: 12]);
        assign w_lane_hi[i*4 +: 4] = i_lanes[i*16+12 +: 4];
    end

    // Only the low 12 bits of each lane carry a length.
    assign w_unused_ok = ^w_lane_hi;

endmodule
`default_nettype wire

// File: rtl/cfg_array_parser.sv
`default_nettype none
// ============================================================================
// Module   : cfg_array_parser
// Purpose  : Parses 30-word configuration packets into shadow registers and
//            commits them atomically to the outputs on a good tail word.
// Revision : 1.0
// ============================================================================
module cfg_array_parser
    import cfg_array_parser_pkg::*;
#(
    parameter PLATFORM = "xilinx"
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [133:0]  in_cap_data,
    input  logic          in_cap_data_wr,
    input  logic          in_cap_data_valid,
    input  logic          in_cap_data_valid_wr,
    output logic [95:0]   out_cap_pkt_len,
    output logic [127:0]  out_cap_tb_size,
    output logic [127:0]  out_cap_tb_rate,
    output logic [831:0]  out_cap_rule,
    output logic [831:0]  out_cap_mask,
    output logic [15:0]   out_cap_samp_freq,
    output logic          out_cap_test_stop,
    output logic [19:0]   out_cap_gcl_time_slot_cycle,
    output logic          out_cap_cfg_update,
    output logic [15:0]   out_cap_cfg_cnt,
    output logic [15:0]   out_cap_err_cnt
);

    localparam logic c_is_xilinx = (PLATFORM == "xilinx");

    logic [STATE_W-1:0] r_state;
    logic [4:0]         r_line;
    cap_cfg_t           r_sh;
    cap_cfg_t           r_out;
    logic               r_update;
    logic [15:0]        r_cfg_cnt;
    logic [15:0]        r_err_cnt;

    logic [STATE_W-1:0] w_state_nxt;
    logic [4:0]         w_line_nxt;
    logic               w_err;
    logic               w_commit;
    logic [1:0]         w_flag;
    logic [127:0]       w_payload;
    logic [95:0]        w_len;
    logic               w_eth_ok;
    logic               w_last_word;
    logic               w_unused_ok;

    assign w_flag      = in_cap_data[133:132];
    assign w_payload   = in_cap_data[127:0];
    assign w_eth_ok    = (w_payload[31:16] == ETHERTYPE) && (w_payload[15:12] == CFG_TYPE);
    assign w_last_word = (r_state == ST_SSM_CA) && (r_line == SSM_LINES - 5'd1);
    assign w_unused_ok = ^{in_cap_data[131:128], c_is_xilinx};

    cap_len_unpack u_len (
        .i_lanes (w_payload),
        .o_len   (w_len)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_line_nxt  = r_line;
        w_err       = 1'b0;
        w_commit    = 1'b0;
        if (in_cap_data_wr) begin
            if (w_flag == FLAG_HEAD) begin
                // A head always restarts; outside IDLE it aborts a packet.
                w_err       = (r_state != ST_IDLE);
                w_state_nxt = ST_MD1;
                w_line_nxt  = 5'd0;
            end else if (r_state == ST_DISCARD) begin
                if (w_flag == FLAG_TAIL) begin
                    w_state_nxt = ST_IDLE;
                end
            end else if (r_state != ST_IDLE) begin
                if (w_flag == FLAG_TAIL) begin
                    w_commit    = w_last_word && in_cap_data_valid_wr && in_cap_data_valid;
                    w_err       = !w_commit;
                    w_state_nxt = ST_IDLE;
                    w_line_nxt  = 5'd0;
                end else begin
                    case (r_state)
                        ST_MD1:     w_state_nxt = ST_ETH;
                        ST_ETH:     w_state_nxt = w_eth_ok ? ST_ENC_MD0 : ST_DISCARD;
                        ST_ENC_MD0: w_state_nxt = ST_ENC_MD1;
                        ST_ENC_MD1: begin
                            w_state_nxt = ST_PGM_CA;
                            w_line_nxt  = 5'd0;
                        end
                        ST_PGM_CA: begin
                            if (r_line == PGM_LINES - 5'd1) begin
                                w_state_nxt = ST_FSM_CA;
                                w_line_nxt  = 5'd0;
                            end else begin
                                w_line_nxt = r_line + 5'd1;
                            end
                        end
                        ST_FSM_CA: begin
                            if (r_line == FSM_LINES - 5'd1) begin
                                w_state_nxt = ST_SSM_CA;
                                w_line_nxt  = 5'd0;
                            end else begin
                                w_line_nxt = r_line + 5'd1;
                            end
                        end
                        ST_SSM_CA: begin
                            if (w_last_word) begin
                                w_err       = 1'b1;
                                w_state_nxt = ST_DISCARD;
                                w_line_nxt  = 5'd0;
                            end else begin
                                w_line_nxt = r_line + 5'd1;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                            w_line_nxt  = 5'd0;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_line  <= 5'd0;
        end else if (in_cap_data_wr) begin
            r_state <= w_state_nxt;
            r_line  <= w_line_nxt;
        end
    end

    // Shadow capture; aborted packets leave stale data here, never on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh <= '0;
        end else if (in_cap_data_wr) begin
            case (r_state)
                ST_PGM_CA: begin
                    case (r_line)
                        5'd0: begin
                            r_sh.test_stop <= w_payload[20];
                            r_sh.gcl_cycle <= w_payload[19:0];
                        end
                        5'd1: begin
                            for (int b = 0; b < 3; b++) begin
                                r_sh.tb_size[b*16 +: 16] <= w_payload[b*32+16 +: 16];
                                r_sh.tb_rate[b*16 +: 16] <= w_payload[b*32 +: 16];
                            end
                        end
                        5'd2: begin
                            for (int b = 0; b < 3; b++) begin
                                r_sh.tb_size[(b+3)*16 +: 16] <= w_payload[b*32+16 +: 16];
                                r_sh.tb_rate[(b+3)*16 +: 16] <= w_payload[b*32 +: 16];
                            end
                        end
                        5'd3: begin
                            for (int b = 0; b < 2; b++) begin
                                r_sh.tb_size[(b+6)*16 +: 16] <= w_payload[b*32+16 +: 16];
                                r_sh.tb_rate[(b+6)*16 +: 16] <= w_payload[b*32 +: 16];
                            end
                        end
                        5'd4: r_sh.pkt_len <= w_len;
                        default: ;
                    endcase
                end
                ST_FSM_CA: begin
                    if (r_line < FSM_LINES - 5'd1) begin
                        if (r_line[0]) begin
                            r_sh.mask[int'(r_line[4:1])*RULE_W +: RULE_W] <= w_payload[RULE_W-1:0];
                        end else begin
                            r_sh.rule[int'(r_line[4:1])*RULE_W +: RULE_W] <= w_payload[RULE_W-1:0];
                        end
                    end
                end
                ST_SSM_CA: begin
                    if (r_line == 5'd0) begin
                        r_sh.samp_freq <= w_payload[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_update  <= 1'b0;
            r_cfg_cnt <= 16'd0;
            r_err_cnt <= 16'd0;
        end else begin
            r_update <= w_commit;
            if (w_commit) begin
                r_out     <= r_sh;
                r_cfg_cnt <= r_cfg_cnt + 16'd1;
            end
            if (w_err) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign out_cap_pkt_len             = r_out.pkt_len;
    assign out_cap_tb_size             = r_out.tb_size;
    assign out_cap_tb_rate             = r_out.tb_rate;
    assign out_cap_rule                = r_out.rule;
    assign out_cap_mask                = r_out.mask;
    assign out_cap_samp_freq           = r_out.samp_freq;
    assign out_cap_test_stop           = r_out.test_stop;
    assign out_cap_gcl_time_slot_cycle = r_out.gcl_cycle;
    assign out_cap_cfg_update          = r_update;
    assign out_cap_cfg_cnt             = r_cfg_cnt;
    assign out_cap_err_cnt             = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cfg_array_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_array_parser
// Purpose  : Randomized scoreboard bench for cfg_array_parser.
// Revision : 1.0
// ============================================================================
module tb_cfg_array_parser;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [133:0]  in_cap_data = '0;
    logic          in_cap_data_wr = 1'b0;
    logic          in_cap_data_valid = 1'b0;
    logic          in_cap_data_valid_wr = 1'b0;
    logic [95:0]   out_cap_pkt_len;
    logic [127:0]  out_cap_tb_size;
    logic [127:0]  out_cap_tb_rate;
    logic [831:0]  out_cap_rule;
    logic [831:0]  out_cap_mask;
    logic [15:0]   out_cap_samp_freq;
    logic          out_cap_test_stop;
    logic [19:0]   out_cap_gcl_time_slot_cycle;
    logic          out_cap_cfg_update;
    logic [15:0]   out_cap_cfg_cnt;
    logic [15:0]   out_cap_err_cnt;

    cfg_array_parser dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .in_cap_data                 (in_cap_data),
        .in_cap_data_wr              (in_cap_data_wr),
        .in_cap_data_valid           (in_cap_data_valid),
        .in_cap_data_valid_wr        (in_cap_data_valid_wr),
        .out_cap_pkt_len             (out_cap_pkt_len),
        .out_cap_tb_size             (out_cap_tb_size),
        .out_cap_tb_rate             (out_cap_tb_rate),
        .out_cap_rule                (out_cap_rule),
        .out_cap_mask                (out_cap_mask),
        .out_cap_samp_freq           (out_cap_samp_freq),
        .out_cap_test_stop           (out_cap_test_stop),
        .out_cap_gcl_time_slot_cycle (out_cap_gcl_time_slot_cycle),
        .out_cap_cfg_update          (out_cap_cfg_update),
        .out_cap_cfg_cnt             (out_cap_cfg_cnt),
        .out_cap_err_cnt             (out_cap_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][15:0]  lane;
        logic [7:0][15:0]  tsize;
        logic [7:0][15:0]  trate;
        logic [7:0][103:0] rule;
        logic [7:0][103:0] mask;
        logic [15:0]       samp;
        logic              stop;
        logic [19:0]       gcl;
    } pcfg_t;

    typedef struct packed {
        logic [95:0]  len;
        logic [127:0] tsize;
        logic [127:0] trate;
        logic [831:0] rule;
        logic [831:0] mask;
        logic [15:0]  samp;
        logic         stop;
        logic [19:0]  gcl;
    } exp_t;

    typedef struct packed {
        exp_t        e;
        logic [15:0] cnt;
        logic [31:0] cyc;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_item;
    int          total = 0;
    int          bad = 0;
    logic [31:0] cyc = 0;
    exp_t        exp_out = '0;
    logic [15:0] exp_cfg = 16'd0;
    logic [15:0] exp_err = 16'd0;
    pcfg_t       ca, cb, cc;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [831:0] act, input logic [831:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic pcfg_t rand_cfg();
        pcfg_t c;
        for (int i = 0; i < 8; i++) begin
            c.lane[i]  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            c.tsize[i] = 16'($urandom);
            c.trate[i] = 16'($urandom);
            c.rule[i]  = 104'(rand128());
            c.mask[i]  = 104'(rand128());
        end
        c.samp = 16'($urandom);
        c.stop = 1'($urandom);
        c.gcl  = 20'($urandom);
        return c;
    endfunction

    // Reference view: what the outputs should hold after committing c.
    function automatic exp_t expect_of(input pcfg_t c);
        exp_t r;
        int   raw;
        for (int i = 0; i < 8; i++) begin
            raw = int'(c.lane[i]) % 4096;
            r.len[i*12 +: 12]    = (raw >= 4) ? 12'(raw - 4) : 12'd0;
            r.tsize[i*16 +: 16]  = c.tsize[i];
            r.trate[i*16 +: 16]  = c.trate[i];
            r.rule[i*104 +: 104] = c.rule[i];
            r.mask[i*104 +: 104] = c.mask[i];
        end
        r.samp = c.samp;
        r.stop = c.stop;
        r.gcl  = c.gcl;
        return r;
    endfunction

    // Payload of word w (1-based) of a packet carrying c.
    function automatic logic [127:0] word_payload(input pcfg_t c, input int w, input bit eth_ok);
        logic [127:0] p;
        int           k;
        p = rand128();
        if (w == 3) begin
            p[31:16] = eth_ok ? 16'hff01 : 16'h0800;
            p[15:12] = 4'h2;
        end else if (w == 6) begin
            p[20]   = c.stop;
            p[19:0] = c.gcl;
        end else if (w >= 7 && w <= 9) begin
            for (int j = 0; j < 3; j++) begin
                k = (w - 7) * 3 + j;
                if (k < 8) p[j*32 +: 32] = {c.tsize[k], c.trate[k]};
            end
        end else if (w == 10) begin
            for (int i = 0; i < 8; i++) p[i*16 +: 16] = c.lane[i];
        end else if (w >= 12 && w <= 27) begin
            k = w - 12;
            p[103:0] = (k % 2 == 0) ? c.rule[k/2] : c.mask[k/2];
        end else if (w == 29) begin
            p[15:0] = c.samp;
        end
        return p;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_cap_data          = {2'($urandom), 4'($urandom), rand128()};
            in_cap_data_wr       = 1'b0;
            in_cap_data_valid_wr = 1'b0;
            in_cap_data_valid    = 1'b0;
        end
    endtask

    task automatic drive_word(input logic [1:0] flag, input logic [127:0] p, input bit vwr, input bit v);
        @(posedge clk); #1;
        in_cap_data          = {flag, 4'($urandom), p};
        in_cap_data_wr       = 1'b1;
        in_cap_data_valid_wr = vwr;
        in_cap_data_valid    = v;
    endtask

    // term: 0 = tail at word nwords, 1 = abandoned (next thing sent is a head),
    //       2 = middle word at 30 followed by a tail at 31.
    task automatic send_pkt(input pcfg_t c, input int nwords, input int term,
                            input bit eth_ok, input bit good, input bit gaps);
        bit         accept;
        bit         err;
        bit         is_tail;
        logic [1:0] flag;
        sb_t        item;
        accept = (term == 0) && (nwords == 30) && eth_ok && good;
        if (term != 0)                  err = 1'b1;
        else if (!eth_ok && nwords > 3) err = 1'b0;
        else                            err = !accept;
        for (int w = 1; w <= nwords; w++) begin
            if (gaps && w > 1 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            is_tail = (term == 0) && (w == nwords);
            flag    = (w == 1) ? 2'b01 : (is_tail ? 2'b10 : 2'b11);
            drive_word(flag, word_payload(c, w, eth_ok), is_tail, is_tail ? good : 1'($urandom));
            if (is_tail && accept) begin
                item.e   = expect_of(c);
                item.cnt = exp_cfg + 16'd1;
                item.cyc = cyc + 32'd1;
                sb_q.push_back(item);
            end
        end
        if (term == 2) drive_word(2'b10, rand128(), 1'b1, 1'($urandom));
        if (term != 1) idle(1);
        if (accept) begin
            exp_cfg = exp_cfg + 16'd1;
            exp_out = expect_of(c);
        end
        if (err) exp_err = exp_err + 16'd1;
    endtask

    task automatic check_state(input string tag);
        idle(3);
        @(negedge clk);
        chk({tag, "_len"},   out_cap_pkt_len, exp_out.len);
        chk({tag, "_size"},  out_cap_tb_size, exp_out.tsize);
        chk({tag, "_rate"},  out_cap_tb_rate, exp_out.trate);
        chk({tag, "_rule"},  out_cap_rule, exp_out.rule);
        chk({tag, "_mask"},  out_cap_mask, exp_out.mask);
        chk({tag, "_samp"},  out_cap_samp_freq, exp_out.samp);
        chk({tag, "_stop"},  out_cap_test_stop, exp_out.stop);
        chk({tag, "_gcl"},   out_cap_gcl_time_slot_cycle, exp_out.gcl);
        chk({tag, "_upd"},   out_cap_cfg_update, 1'b0);
        chk({tag, "_cfg"},   out_cap_cfg_cnt, exp_cfg);
        chk({tag, "_err"},   out_cap_err_cnt, exp_err);
        chk({tag, "_pending"}, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_cap_data_wr = 1'b0;
        exp_out = '0;
        exp_cfg = 16'd0;
        exp_err = 16'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every update pulse must match the oldest expected commit.
    initial begin
        forever begin
            @(negedge clk);
            if (out_cap_cfg_update === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_update: got pulse want none");
                end else begin
                    mon_item = sb_q.pop_front();
                    chk("upd_cycle", cyc, mon_item.cyc);
                    chk("upd_len",   out_cap_pkt_len, mon_item.e.len);
                    chk("upd_size",  out_cap_tb_size, mon_item.e.tsize);
                    chk("upd_rate",  out_cap_tb_rate, mon_item.e.trate);
                    chk("upd_rule",  out_cap_rule, mon_item.e.rule);
                    chk("upd_mask",  out_cap_mask, mon_item.e.mask);
                    chk("upd_samp",  out_cap_samp_freq, mon_item.e.samp);
                    chk("upd_stop",  out_cap_test_stop, mon_item.e.stop);
                    chk("upd_gcl",   out_cap_gcl_time_slot_cycle, mon_item.e.gcl);
                    chk("upd_cnt",   out_cap_cfg_cnt, mon_item.cnt);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_state("reset");

        send_pkt(rand_cfg(), 30, 0, 1'b0, 1'b1, 1'b0);
        check_state("eth_drop");
        chk("eth_drop_err0", out_cap_err_cnt, 16'd0);
        chk("eth_drop_cfg0", out_cap_cfg_cnt, 16'd0);

        ca = rand_cfg();
        ca.lane[0] = 16'h0040;
        ca.rule[0] = 104'h1;
        send_pkt(ca, 30, 0, 1'b1, 1'b1, 1'b0);
        check_state("pkt_a");
        chk("pkt_a_len1",  out_cap_pkt_len[11:0], 12'h03C);
        chk("pkt_a_rule1", out_cap_rule[103:0], 104'h1);
        chk("pkt_a_cnt1",  out_cap_cfg_cnt, 16'd1);

        send_pkt(ca, 30, 0, 1'b1, 1'b1, 1'b1);
        check_state("pkt_a_gaps");
        chk("gaps_len1", out_cap_pkt_len[11:0], 12'h03C);
        chk("gaps_cnt2", out_cap_cfg_cnt, 16'd2);

        send_pkt(rand_cfg(), 20, 0, 1'b1, 1'b1, 1'b0);
        check_state("tail20");
        chk("tail20_err1", out_cap_err_cnt, 16'd1);
        chk("tail20_rule1", out_cap_rule[103:0], 104'h1);

        do_reset();
        check_state("reset2");

        cb = rand_cfg();
        cb.lane[0] = 16'h0002;
        send_pkt(rand_cfg(), 11, 1, 1'b1, 1'b1, 1'b0);
        send_pkt(cb, 30, 0, 1'b1, 1'b1, 1'b0);
        check_state("head12");
        chk("head12_err1", out_cap_err_cnt, 16'd1);
        chk("head12_cfg1", out_cap_cfg_cnt, 16'd1);
        chk("sat_len1_0",  out_cap_pkt_len[11:0], 12'd0);

        for (int n = 0; n < 16; n++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: send_pkt(rand_cfg(), 30, 0, 1'b1, 1'b1, 1'($urandom));
                1: send_pkt(rand_cfg(), $urandom_range(2, 29), 0, 1'b1, 1'($urandom), 1'($urandom));
                2: send_pkt(rand_cfg(), 30, 0, 1'b1, 1'b0, 1'($urandom));
                3: send_pkt(rand_cfg(), 30, 2, 1'b1, 1'b1, 1'($urandom));
                default: send_pkt(rand_cfg(), 30, 0, 1'b0, 1'b1, 1'($urandom));
            endcase
            check_state("rand");
        end

        // Reset asserted while word 15 is on the bus.
        cc = rand_cfg();
        for (int w = 1; w <= 14; w++)
            drive_word((w == 1) ? 2'b01 : 2'b11, word_payload(cc, w, 1'b1), 1'b0, 1'b0);
        drive_word(2'b11, word_payload(cc, 15, 1'b1), 1'b0, 1'b0);
        rst_n   = 1'b0;
        exp_out = '0;
        exp_cfg = 16'd0;
        exp_err = 16'd0;
        #1;
        chk("rst15_len",  out_cap_pkt_len, '0);
        chk("rst15_rule", out_cap_rule, '0);
        chk("rst15_cfg",  out_cap_cfg_cnt, 16'd0);
        chk("rst15_err",  out_cap_err_cnt, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int w = 16; w <= 30; w++)
            drive_word((w == 30) ? 2'b10 : 2'b11, word_payload(cc, w, 1'b1), w == 30, 1'b1);
        check_state("rst15_rest");

        send_pkt(cc, 30, 0, 1'b1, 1'b1, 1'b1);
        check_state("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
